// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer slice.
//   state_t       : serializer FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH : default parallel word width
//   cnt_width()   : bit-counter width for a given word width
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear to 0 (wins over en)
//   en           : advance by one; saturates at WIDTH-1
//   count        : current bit position
//   tc           : terminal count, high when count == WIDTH-1
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clr,
  input  logic                        en,
  output logic [cnt_width(WIDTH)-1:0] count,
  output logic                        tc
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

  always_comb begin
    tc = (count == LAST);
  end

endmodule

// File: rtl/piso16_serializer.sv
// Parallel-in, serial-out transmitter with ready/valid on both sides.
//   clk, reset_n : clock, asynchronous active-low reset
//   d            : parallel word, sampled only on the load edge
//   load_valid   : d is valid
//   load_ready   : word can be accepted this cycle (combinational from
//                  tx_ready so the next word can load on the last-bit edge)
//   sout         : current serial bit (registered)
//   tx_valid     : sout is valid
//   tx_ready     : downstream consumes sout this cycle
//   tx_last      : sout is the final bit of the word
module piso16_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count;
  logic             tc;
  logic             beat;
  logic             last_beat;
  logic             load_fire;

  // Counter is cleared both on a load and when the last bit goes out, so
  // it always restarts from 0 and never wraps.
  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (load_fire || last_beat),
    .en      (beat),
    .count   (count),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    tx_valid   = (state_q == SHIFT);
    tx_last    = tx_valid && tc;
    beat       = tx_valid && tx_ready;
    last_beat  = beat && tc;
    load_ready = !tx_valid || (tx_last && tx_ready);
    load_fire  = load_valid && load_ready;
    state_d    = state_q;
    case (state_q)
      IDLE:    if (load_fire) state_d = SHIFT;
      SHIFT:   if (last_beat) state_d = load_fire ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Zero fill means the register drains to 0 once a word completes, so
  // sout reads 0 while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
    end else if (load_fire) begin
      shreg_q <= d;
    end else if (beat) begin
      shreg_q <= shifted;
    end
  end

  always_comb begin
    sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count <= CW'(WIDTH - 1));
    end
  end

endmodule
